// File: rtl/cfg_reg_arbiter.sv
// Five-entry 8-bit configuration register bank with a boot loader and a
// two-port (A/B) arbitrated single-beat write path using req/ack handshakes.
module cfg_reg_arbiter #(
   parameter logic [7:0] DEF0       = 8'h00,
   parameter logic [7:0] DEF1       = 8'h00,
   parameter logic [7:0] DEF2       = 8'h00,
   parameter logic [7:0] DEF3       = 8'h00,
   parameter logic [7:0] DEF4       = 8'h00,
   parameter bit         FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_req,
   input  logic [6:0] a_addr,
   input  logic [7:0] a_data,
   output logic       a_ack,
   output logic       a_err,
   input  logic       b_req,
   input  logic [6:0] b_addr,
   input  logic [7:0] b_data,
   output logic       b_ack,
   output logic       b_err,
   output logic [7:0] reg0,
   output logic [7:0] reg1,
   output logic [7:0] reg2,
   output logic [7:0] reg3,
   output logic [7:0] reg4,
   output logic       upd_valid,
   output logic [2:0] upd_addr,
   output logic       busy
);

   typedef enum logic [1:0] {BOOT, IDLE, WRITE} state_t;

   state_t     state;
   logic [2:0] boot_idx;
   logic       last_b;
   logic       lat_b;
   logic [6:0] lat_addr;
   logic [7:0] lat_data;
   logic [7:0] bank [5];
   logic       grant_b;

   function automatic logic [7:0] boot_value(input logic [2:0] idx);
      case (idx)
         3'd0:    boot_value = DEF0;
         3'd1:    boot_value = DEF1;
         3'd2:    boot_value = DEF2;
         3'd3:    boot_value = DEF3;
         3'd4:    boot_value = DEF4;
         default: boot_value = 8'h00;
      endcase
   endfunction

   // On a tie, round-robin hands the grant to whichever port did not win last.
   always_comb begin
      grant_b = 1'b0;
      if (b_req && !a_req)
         grant_b = 1'b1;
      else if (a_req && b_req)
         grant_b = FIXED_PRIO ? 1'b0 : !last_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT;
         boot_idx  <= 3'd0;
         last_b    <= 1'b1;
         a_ack     <= 1'b0;
         a_err     <= 1'b0;
         b_ack     <= 1'b0;
         b_err     <= 1'b0;
         upd_valid <= 1'b0;
         upd_addr  <= 3'd0;
         busy      <= 1'b1;
         for (int i = 0; i < 5; i++)
            bank[i] <= 8'h00;
      end else begin
         a_ack     <= 1'b0;
         a_err     <= 1'b0;
         b_ack     <= 1'b0;
         b_err     <= 1'b0;
         upd_valid <= 1'b0;
         case (state)
            BOOT: begin
               bank[boot_idx] <= boot_value(boot_idx);
               upd_valid      <= 1'b1;
               upd_addr       <= boot_idx;
               if (boot_idx == 3'd4) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  boot_idx <= boot_idx + 3'd1;
               end
            end
            IDLE: begin
               if (a_req || b_req) begin
                  lat_b    <= grant_b;
                  lat_addr <= grant_b ? b_addr : a_addr;
                  lat_data <= grant_b ? b_data : a_data;
                  last_b   <= grant_b;
                  state    <= WRITE;
                  busy     <= 1'b1;
               end
            end
            WRITE: begin
               // Out-of-range addresses are acknowledged with err and write nothing.
               if (lat_addr <= 7'd4) begin
                  bank[lat_addr[2:0]] <= lat_data;
                  upd_valid           <= 1'b1;
                  upd_addr            <= lat_addr[2:0];
               end
               if (lat_b) begin
                  b_ack <= 1'b1;
                  b_err <= (lat_addr > 7'd4);
               end else begin
                  a_ack <= 1'b1;
                  a_err <= (lat_addr > 7'd4);
               end
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= BOOT;
               boot_idx <= 3'd0;
               busy     <= 1'b1;
            end
         endcase
      end
   end

   assign reg0 = bank[0];
   assign reg1 = bank[1];
   assign reg2 = bank[2];
   assign reg3 = bank[3];
   assign reg4 = bank[4];

endmodule
